// File: rtl/drum_dot_acc_if.sv
// Operand-pair input stream and dot-product result stream for drum_dot_acc.
interface drum_dot_acc_if #(
    parameter int n_in  = 16,
    parameter int m_in  = 16,
    parameter int acc_w = 35
);
    logic              in_valid;
    logic              in_ready;
    logic [n_in-1:0]   in_a;
    logic [m_in-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [acc_w-1:0]  out_sum;
    logic              out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );
endinterface

// File: rtl/drum_dot_acc.sv
// Streaming dot product of DRUM approximate products over vec_len pairs.
// Define DRUM_ACC_SAT_EN for a saturating accumulator with sticky out_sat.

// Per-operand DRUM encoder: k-bit window below the leading one, LSB forced to 1.
module drum_enc #(
    parameter int N   = 16,
    parameter int K   = 6,
    parameter int SHW = 5
) (
    input  logic [N-1:0]   x,
    output logic [K-1:0]   t,
    output logic [SHW-1:0] sh
);
    logic [SHW-1:0] lead;

    always_comb begin
        lead = '0;
        for (int i = 0; i < N; i++)
            if (x[i]) lead = SHW'(i);
        sh = '0;
        if (lead >= SHW'(K)) sh = lead - SHW'(K - 1);
        t = K'(x >> sh);
        // operands below 2^K pass through exactly
        if (sh != '0) t[0] = 1'b1;
    end
endmodule

module drum_dot_acc #(
    parameter int k_in    = 6,
    parameter int n_in    = 16,
    parameter int m_in    = 16,
    parameter int vec_len = 8,
    parameter int acc_w   = n_in + m_in + $clog2(vec_len)
) (
    input  logic          clk,
    input  logic          rst_n,
    drum_dot_acc_if.slave io
);
    localparam int PW  = n_in + m_in;
    localparam int SHW = $clog2(n_in + 1);
    localparam int CW  = (vec_len > 1) ? $clog2(vec_len) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(vec_len - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0][n_in-1:0]    op_q, op_d;
    logic [2:1]              vld_pipe_q, vld_pipe_d;
    logic [2:1]              last_pipe_q, last_pipe_d;
    logic [PW-1:0]           p_q, p_d, core_p;
    logic [acc_w-1:0]        acc_q, acc_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [1:0][k_in-1:0]    t;
    logic [1:0][SHW-1:0]     sh;
    logic                    accept, out_hs, last_in;
`ifdef DRUM_ACC_SAT_EN
    logic                    sat_q, sat_d;
    logic [acc_w:0]          sum_w;
`endif

    genvar g;
    for (g = 0; g < 2; g++) begin : g_enc
        drum_enc #(.N(n_in), .K(k_in), .SHW(SHW)) u_enc (
            .x  (op_q[g]),
            .t  (t[g]),
            .sh (sh[g])
        );
    end

    assign core_p = (PW'(t[0]) * PW'(t[1])) << ({1'b0, sh[0]} + {1'b0, sh[1]});

    always_comb begin
        accept  = io.in_valid & in_ready_q;
        out_hs  = out_valid_q & io.out_ready;
        last_in = accept & (cnt_q == CNT_LAST);

        op_d  = op_q;
        cnt_d = cnt_q;
        if (accept) begin
            op_d  = {io.in_b, io.in_a};
            cnt_d = last_in ? '0 : cnt_q + CW'(1);
        end
        vld_pipe_d  = {vld_pipe_q[1], accept};
        last_pipe_d = {last_pipe_q[1], last_in};
        p_d         = core_p;

        acc_d = acc_q;
`ifdef DRUM_ACC_SAT_EN
        sum_w = {1'b0, acc_q} + (acc_w + 1)'(p_q);
        sat_d = sat_q;
        if (vld_pipe_q[2]) begin
            acc_d = sum_w[acc_w] ? '1 : sum_w[acc_w-1:0];
            sat_d = sat_q | sum_w[acc_w];
        end
        if (out_hs) sat_d = 1'b0;
`else
        if (vld_pipe_q[2]) acc_d = acc_q + acc_w'(p_q);
`endif
        if (out_hs) acc_d = '0;

        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: if (last_in) begin
                state_d    = DRAIN;
                in_ready_d = 1'b0;
            end
            DRAIN: if (vld_pipe_q[2] & last_pipe_q[2]) begin
                state_d     = OUT;
                out_valid_d = 1'b1;
            end
            OUT: if (out_hs) begin
                state_d     = ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            op_q        <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            p_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DRUM_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DRUM_ACC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_sum   = acc_q;
`ifdef DRUM_ACC_SAT_EN
    assign io.out_sat   = sat_q & out_valid_q;
`else
    assign io.out_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_drum_dot_acc.sv
// Directed bench for drum_dot_acc: four instances cover vec_len 8/1/4 and a narrow accumulator.
module tb_drum_dot_acc;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic stable;

    always #5 clk = ~clk;

    drum_dot_acc_if #(.n_in(16), .m_in(16), .acc_w(35)) if8 ();
    drum_dot_acc_if #(.n_in(16), .m_in(16), .acc_w(32)) if1 ();
    drum_dot_acc_if #(.n_in(16), .m_in(16), .acc_w(34)) if4 ();
    drum_dot_acc_if #(.n_in(16), .m_in(16), .acc_w(20)) ifo ();

    drum_dot_acc #(.k_in(6), .n_in(16), .m_in(16), .vec_len(8), .acc_w(35)) u_d8 (
        .clk(clk), .rst_n(rst_n), .io(if8.slave));
    drum_dot_acc #(.k_in(6), .n_in(16), .m_in(16), .vec_len(1), .acc_w(32)) u_d1 (
        .clk(clk), .rst_n(rst_n), .io(if1.slave));
    drum_dot_acc #(.k_in(6), .n_in(16), .m_in(16), .vec_len(4), .acc_w(34)) u_d4 (
        .clk(clk), .rst_n(rst_n), .io(if4.slave));
    drum_dot_acc #(.k_in(6), .n_in(16), .m_in(16), .vec_len(2), .acc_w(20)) u_ov (
        .clk(clk), .rst_n(rst_n), .io(ifo.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int    tv_a [5] = '{1000, 63, 64, 37, 5};
    int    tv_b [5] = '{1000, 63, 64, 1000, 7};
    int    tv_e [5] = '{1016064, 3969, 4356, 37296, 35};

    initial begin
        {if8.in_valid, if8.in_a, if8.in_b, if8.out_ready} = '0;
        {if1.in_valid, if1.in_a, if1.in_b, if1.out_ready} = '0;
        {if4.in_valid, if4.in_a, if4.in_b, if4.out_ready} = '0;
        {ifo.in_valid, ifo.in_a, ifo.in_b, ifo.out_ready} = '0;

        repeat (2) tick();
        chk("rst_out_valid", if8.out_valid, 0);
        chk("rst_out_sum", if8.out_sum, 0);
        chk("rst_out_sat", ifo.out_sat, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", if8.in_ready, 1);

        // exact path: 8 x (3*5), first accept at edge 0
        if8.in_a = 16'd3; if8.in_b = 16'd5; if8.in_valid = 1'b1;
        repeat (8) tick();
        chk("exact_in_ready_drain", if8.in_ready, 0);
        tick();
        chk("exact_no_early_valid", if8.out_valid, 0);
        tick();
        chk("exact_out_valid", if8.out_valid, 1);
        chk("exact_out_sum", if8.out_sum, 120);
        chk("exact_out_sat", if8.out_sat, 0);

        // back-pressure with in_valid still asserted
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (if8.out_sum !== 35'd120 || if8.in_ready !== 1'b0 || if8.out_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        if8.in_a = 16'd1; if8.in_b = 16'd1; if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        chk("bp_hs_valid_drop", if8.out_valid, 0);
        chk("bp_in_ready_back", if8.in_ready, 1);
        repeat (8) tick();
        if8.in_valid = 1'b0;
        repeat (2) tick();
        chk("bp_next_valid", if8.out_valid, 1);
        chk("bp_next_sum", if8.out_sum, 8);
        if8.out_ready = 1'b1; tick(); if8.out_ready = 1'b0;

        // reset mid-vector after 3 accepts of 7*7
        if8.in_a = 16'd7; if8.in_b = 16'd7; if8.in_valid = 1'b1;
        repeat (3) tick();
        if8.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", if8.out_valid, 0);
        chk("midrst_out_sum", if8.out_sum, 0);
        chk("midrst_out_sat", if8.out_sat, 0);
        tick();
        rst_n = 1'b1;
        tick();
        if8.in_a = 16'd1; if8.in_b = 16'd1; if8.in_valid = 1'b1;
        repeat (8) tick();
        if8.in_valid = 1'b0;
        repeat (2) tick();
        chk("postrst_valid", if8.out_valid, 1);
        chk("postrst_sum", if8.out_sum, 8);
        if8.out_ready = 1'b1; tick(); if8.out_ready = 1'b0;

        // vec_len=1: approximate and exact-boundary products
        for (int i = 0; i < 5; i++) begin
            if1.in_a = 16'(tv_a[i]); if1.in_b = 16'(tv_b[i]); if1.in_valid = 1'b1;
            tick();
            if1.in_valid = 1'b0;
            chk($sformatf("v1_in_ready_%0d", i), if1.in_ready, 0);
            tick();
            chk($sformatf("v1_early_%0d", i), if1.out_valid, 0);
            tick();
            chk($sformatf("v1_valid_%0d", i), if1.out_valid, 1);
            chk($sformatf("v1_sum_%0d", i), if1.out_sum, 64'(tv_e[i]));
            if1.out_ready = 1'b1; tick(); if1.out_ready = 1'b0;
        end

        // bubbles: 2*2 with in_valid toggling
        if4.in_a = 16'd2; if4.in_b = 16'd2;
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1; tick();
            if4.in_valid = 1'b0; tick();
        end
        chk("bub_in_ready", if4.in_ready, 0);
        chk("bub_early", if4.out_valid, 0);
        tick();
        chk("bub_valid", if4.out_valid, 1);
        chk("bub_sum", if4.out_sum, 16);
        if4.out_ready = 1'b1; tick(); if4.out_ready = 1'b0;

        // overflow on a 20-bit accumulator
        ifo.in_a = 16'd1000; ifo.in_b = 16'd1000; ifo.in_valid = 1'b1;
        repeat (2) tick();
        ifo.in_valid = 1'b0;
        tick();
        chk("ov_early", ifo.out_valid, 0);
        tick();
        chk("ov_valid", ifo.out_valid, 1);
`ifdef DRUM_ACC_SAT_EN
        chk("ov_sum", ifo.out_sum, 1048575);
        chk("ov_sat", ifo.out_sat, 1);
`else
        chk("ov_sum", ifo.out_sum, 983552);
        chk("ov_sat", ifo.out_sat, 0);
`endif
        ifo.out_ready = 1'b1; tick(); ifo.out_ready = 1'b0;
        chk("ov_sat_cleared", ifo.out_sat, 0);
        chk("ov_sum_cleared", ifo.out_sum, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
